// File: rtl/shift_register_pkg.sv
// Shared types and the next-value function for the universal shift register.
// The function works on a MAX_W-bit container so one definition serves every
// WIDTH; bits above the register width are always returned as zero.
package shift_register_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    MODE_HOLD       = 3'd0,
    MODE_SHIFT_UP   = 3'd1,
    MODE_SHIFT_DOWN = 3'd2,
    MODE_ROT_UP     = 3'd3,
    MODE_ROT_DOWN   = 3'd4,
    MODE_LOAD       = 3'd5
  } shift_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  // True for the four modes a burst may repeat (shift/rotate up/down).
  function automatic logic is_burst_mode(input logic [2:0] mode);
    return (mode >= 3'd1) && (mode <= 3'd4);
  endfunction

  // One step of the register; reserved codes 6/7 fall into HOLD.
  function automatic logic [MAX_W-1:0] next_value(
    input shift_mode_t      mode,
    input logic [MAX_W-1:0] r,
    input logic             serial_in,
    input logic [MAX_W-1:0] parallel_in,
    input int unsigned      width
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] sin;
    logic [MAX_W-1:0] msb;
    logic [MAX_W-1:0] lsb;
    mask = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    sin  = {{(MAX_W-1){1'b0}}, serial_in};
    msb  = (r >> (width - 1)) & 64'd1;
    lsb  = r & 64'd1;
    case (mode)
      MODE_SHIFT_UP:   return ((r << 1) | sin) & mask;
      MODE_SHIFT_DOWN: return ((r & mask) >> 1) | (sin << (width - 1));
      MODE_ROT_UP:     return ((r << 1) | msb) & mask;
      MODE_ROT_DOWN:   return ((r & mask) >> 1) | (lsb << (width - 1));
      MODE_LOAD:       return parallel_in & mask;
      default:         return r & mask;
    endcase
  endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst controller: decides when the register steps and with which mode.
// In IDLE a step follows Enable_In with the live mode; a Start_In with a
// shift/rotate mode latches mode and count and runs that many steps.
module shift_burst_ctrl
  import shift_register_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [2:0]         mode_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   count_i,
  output logic               step_o,
  output logic [2:0]         step_mode_o,
  output burst_state_t       state_o,
  output logic               done_o
);

  burst_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             done_q, done_d;

  // State, remaining-step counter, latched mode and done pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Next state and step strobe; done is registered so it pulses one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    step_o      = 1'b0;
    step_mode_o = mode_i;
    case (state_q)
      IDLE: begin
        if (start_i && is_burst_mode(mode_i)) begin
          if (count_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = BURST;
            cnt_d   = count_i;
            mode_d  = mode_i;
          end
        end else if (enable_i) begin
          step_o = 1'b1;
        end
      end
      BURST: begin
        step_o      = 1'b1;
        step_mode_o = mode_q;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign done_o  = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with hold/shift/rotate/load modes and
// a burst controller (Start_In runs Shift_Count_In steps, Busy/Done report).
// Optional macro SHIFT_REG_PARITY_EN adds Parity_Out = XOR of the register.
module universal_shift_register
  import shift_register_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               Clk_In,
  input  logic               Reset_In,
  input  logic               Enable_In,
  input  logic [2:0]         Mode_In,
  input  logic               Serial_Data_In,
  input  logic [WIDTH-1:0]   Parallel_Data_In,
  input  logic               Start_In,
  input  logic [CNT_W-1:0]   Shift_Count_In,
  output logic [WIDTH-1:0]   Parallel_Data_Out,
  output logic               Msb_Out,
  output logic               Lsb_Out,
  output logic               Busy_Out,
  output logic               Done_Out
`ifdef SHIFT_REG_PARITY_EN
  ,output logic              Parity_Out
`endif
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [MAX_W-1:0] next_full;
  logic             step;
  logic [2:0]       step_mode;
  burst_state_t     ctrl_state;

  shift_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk_i       (Clk_In),
    .rst_i       (Reset_In),
    .enable_i    (Enable_In),
    .mode_i      (Mode_In),
    .start_i     (Start_In),
    .count_i     (Shift_Count_In),
    .step_o      (step),
    .step_mode_o (step_mode),
    .state_o     (ctrl_state),
    .done_o      (Done_Out)
  );

  // Register next value: one step of the selected mode when strobed.
  always_comb begin
    next_full = next_value(shift_mode_t'(step_mode), MAX_W'(shreg_q),
                           Serial_Data_In, MAX_W'(Parallel_Data_In), WIDTH);
    shreg_d   = step ? WIDTH'(next_full) : shreg_q;
  end

  // Register storage with synchronous reset.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) shreg_q <= '0;
    else          shreg_q <= shreg_d;
  end

  assign Parallel_Data_Out = shreg_q;
  assign Msb_Out           = shreg_q[WIDTH-1];
  assign Lsb_Out           = shreg_q[0];
  assign Busy_Out          = (ctrl_state == BURST);

`ifdef SHIFT_REG_PARITY_EN
  assign Parity_Out = ^shreg_q;
`endif

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the fixed 16-bit serial-in/serial-out shift register. It is a WIDTH-bit universal shift register with hold, shift-up, shift-down, rotate-up, rotate-down and parallel-load modes. It adds a burst controller that applies N consecutive shift/rotate steps after a single start pulse, with busy/done handshake. It serves as the general-purpose shifter for serialisers, CRC/LFSR front ends and test pattern generators.

Parameters:
WIDTH, 16, register length in bits; legal range 2 to 64.
CNT_W, $clog2(WIDTH+1), width of the burst count; derived, do not override.

Ports:
Clk_In  input  1  clock; all state changes on the rising edge.
Reset_In  input  1  synchronous, active-high reset.
Enable_In  input  1  single-step enable; used only in IDLE.
Mode_In  input  3  operation code (see Behaviour).
Serial_Data_In  input  1  bit inserted by shift modes.
Parallel_Data_In  input  WIDTH  load value for LOAD mode.
Start_In  input  1  starts a burst of Shift_Count_In steps.
Shift_Count_In  input  CNT_W  number of burst steps.
Parallel_Data_Out  output  WIDTH  register contents.
Msb_Out  output  1  register bit WIDTH-1.
Lsb_Out  output  1  register bit 0.
Busy_Out  output  1  high while a burst is executing.
Done_Out  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (Reset_In=1 at an edge): register=0, state=IDLE, Busy_Out=0, Done_Out=0, step counter=0. Reset overrides every other input, including mid-burst; the burst is abandoned and Done_Out is not pulsed.
- Mode codes: 0 HOLD; 1 SHIFT_UP {r[W-2:0],Serial_Data_In}; 2 SHIFT_DOWN {Serial_Data_In,r[W-1:1]}; 3 ROT_UP {r[W-2:0],r[W-1]}; 4 ROT_DOWN {r[0],r[W-1:1]}; 5 LOAD Parallel_Data_In; 6 and 7 are reserved and behave as HOLD.
- Msb_Out, Lsb_Out and Parallel_Data_Out are combinational from the register, so the result of a step is visible in the cycle after the edge.
- IDLE, Start_In=0, Enable_In=1: apply Mode_In once at the edge. With Enable_In=0: hold.
- IDLE, Start_In=1, Mode_In in {1,2,3,4}, Shift_Count_In=N>0: at edge 0, latch the mode and N, go to BURST, Busy_Out=1. The register does not change at edge 0 (Enable_In is ignored).
- BURST: at edges 1..N, apply the latched mode. Serial_Data_In is sampled live at each edge. At edge N: state=IDLE, Busy_Out=0, Done_Out=1 for exactly one cycle.
- Start_In with N=0: no step, state stays IDLE, Done_Out=1 at edge 0.
- Start_In with Mode_In in {0,5,6,7}: ignored entirely. Enable_In processing applies as if Start_In=0.
- In BURST, Start_In, Enable_In and Mode_In are ignored.
- Back-to-back: Start_In may be asserted in the Done_Out cycle (state is IDLE) and is accepted.
- N greater than WIDTH is honoured without clamping; rotations wrap.

Optional Feature:
SHIFT_REG_PARITY_EN
- Defined: adds output Parity_Out (1 bit) = XOR-reduction of the register, combinational; reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package shift_register_pkg: enum shift_mode_t (3-bit, codes above), enum burst_state_t {IDLE, BURST}, and a function next_value(mode, reg, serial_in, parallel_in) shared with the verification model.
- Sub-module shift_burst_ctrl: owns the FSM, step counter, Busy_Out and Done_Out. Its outputs are a step strobe and the latched mode.

Test Plan:
- WIDTH=8, reset, then LOAD 8'hA5 via Enable_In -> Parallel_Data_Out=8'hA5, Msb_Out=1, Lsb_Out=1.
- 8'hA5, Enable_In=1, SHIFT_UP with Serial_Data_In=0 for 3 cycles -> 8'h28.
- 8'h81, Start_In with ROT_DOWN, N=3 -> Busy_Out high for 3 cycles, result 8'h30, Done_Out pulse at edge 3.
- Start_In with N=0 -> Done_Out the next cycle, register unchanged, Busy_Out never high.
- Reset_In asserted at burst edge 2 of N=5 -> register=0, Busy_Out=0, no Done_Out pulse.
- Start_In held in the Done_Out cycle, SHIFT_DOWN N=8 with Serial_Data_In=1 -> second burst accepted, final value 8'hFF; with SHIFT_REG_PARITY_EN defined, Parity_Out=0.
